// File: rtl/dispatch_queue.sv
// dispatch_queue: instruction queue + decode + operand resolution + dispatch.
// Buffers fetched instructions in an IQ_DEPTH-entry FIFO, decodes the head,
// resolves its sources against regfile/ROB and issues a registered one-cycle
// packet to the RS or the LSB together with a ROB allocation pulse.
// Optional feature macro: DISPATCH_CDB_FWD_EN (capture CDB data for a pending
// source in the dispatch cycle). Without it the cdb_* ports are ignored.
module dispatch_queue #(
  parameter int unsigned IQ_DEPTH = 8,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned OP_W     = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_inst,
  input  logic [XLEN-1:0]  fetch_pc,
  input  logic             fetch_ls,
  output logic             fetch_ready,
  output logic [4:0]       rs1_idx,
  output logic [4:0]       rs2_idx,
  input  logic [TAG_W-1:0] reg_tag1,
  input  logic [TAG_W-1:0] reg_tag2,
  input  logic [XLEN-1:0]  reg_data1,
  input  logic [XLEN-1:0]  reg_data2,
  input  logic             rob_ready1,
  input  logic             rob_ready2,
  input  logic [XLEN-1:0]  rob_data1,
  input  logic [XLEN-1:0]  rob_data2,
  input  logic             rob_free,
  input  logic [TAG_W-1:0] rob_tag,
  output logic             rob_alloc,
  output logic [OP_W-1:0]  rob_op,
  output logic [4:0]       rob_rd,
  output logic [4:0]       rename_rd,
  output logic [TAG_W-1:0] rename_tag,
  input  logic             rs_free,
  input  logic             lsb_free,
  output logic             issue_rs,
  output logic             issue_lsb,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_dest,
  output logic [TAG_W-1:0] iss_qj,
  output logic [TAG_W-1:0] iss_qk,
  output logic [XLEN-1:0]  iss_vj,
  output logic [XLEN-1:0]  iss_vk,
  output logic [XLEN-1:0]  iss_imm,
  output logic [XLEN-1:0]  iss_pc,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             illegal_out
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [5:0] {
    OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  logic [31:0]     q_inst [IQ_DEPTH];
  logic [XLEN-1:0] q_pc   [IQ_DEPTH];
  logic            q_ls   [IQ_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic            empty, push, pop, dispatch, drop;
  logic [31:0]     inst;
  logic            head_ls;
  op_e             dec_op;
  logic            legal, use1, use2, has_rd;
  logic [31:0]     imm32;
  logic [TAG_W-1:0] src1_q, src2_q;
  logic [XLEN-1:0]  src1_v, src2_v;

  assign empty       = (count == '0);
  assign fetch_ready = (count != CW'(IQ_DEPTH));
  assign push        = fetch_valid && fetch_ready && !clear_in;
  assign inst        = q_inst[head];
  assign head_ls     = q_ls[head];
  assign rs1_idx     = inst[19:15];
  assign rs2_idx     = inst[24:20];

  assign dispatch = !empty && legal && rob_free && (head_ls ? lsb_free : rs_free) && !clear_in;
  assign drop     = !empty && !legal && !clear_in;
  assign pop      = dispatch || drop;

`ifndef DISPATCH_CDB_FWD_EN
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_data};
`endif

  // Resolve one source: regfile value, ROB value, (optionally) CDB value, or wait on tag.
  function automatic logic [TAG_W+XLEN-1:0] resolve(
    input logic             used,
    input logic [TAG_W-1:0] tag,
    input logic [XLEN-1:0]  rdata,
    input logic             rrdy,
    input logic [XLEN-1:0]  robd
  );
    logic [TAG_W-1:0] q;
    logic [XLEN-1:0]  v;
    q = '0;
    v = '0;
    if (used) begin
      if (tag == '0)
        v = rdata;
      else if (rrdy)
        v = robd;
`ifdef DISPATCH_CDB_FWD_EN
      else if (cdb_valid && (cdb_tag == tag))
        v = cdb_data;
`endif
      else
        q = tag;
    end
    return {q, v};
  endfunction

  // Decode the head entry: op type, legality, used sources, rd presence, immediate.
  always_comb begin
    dec_op = OP_NONE;
    legal  = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    has_rd = 1'b0;
    imm32  = '0;
    case (inst[6:0])
      7'b0110111: begin dec_op = OP_LUI;   legal = 1'b1; has_rd = 1'b1; imm32 = {inst[31:12], 12'b0}; end
      7'b0010111: begin dec_op = OP_AUIPC; legal = 1'b1; has_rd = 1'b1; imm32 = {inst[31:12], 12'b0}; end
      7'b1101111: begin
        dec_op = OP_JAL; legal = 1'b1; has_rd = 1'b1;
        imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        dec_op = OP_JALR; legal = (inst[14:12] == 3'b000); use1 = 1'b1; has_rd = 1'b1;
        imm32  = {{20{inst[31]}}, inst[31:20]};
      end
      7'b1100011: begin
        legal = 1'b1; use1 = 1'b1; use2 = 1'b1;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        case (inst[14:12])
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: legal  = 1'b0;
        endcase
      end
      7'b0000011: begin
        legal = 1'b1; use1 = 1'b1; has_rd = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
        case (inst[14:12])
          3'b000:  dec_op = OP_LB;
          3'b001:  dec_op = OP_LH;
          3'b010:  dec_op = OP_LW;
          3'b100:  dec_op = OP_LBU;
          3'b101:  dec_op = OP_LHU;
          default: legal  = 1'b0;
        endcase
      end
      7'b0100011: begin
        legal = 1'b1; use1 = 1'b1; use2 = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        case (inst[14:12])
          3'b000:  dec_op = OP_SB;
          3'b001:  dec_op = OP_SH;
          3'b010:  dec_op = OP_SW;
          default: legal  = 1'b0;
        endcase
      end
      7'b0010011: begin
        legal = 1'b1; use1 = 1'b1; has_rd = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
        case (inst[14:12])
          3'b000:  dec_op = OP_ADDI;
          3'b010:  dec_op = OP_SLTI;
          3'b011:  dec_op = OP_SLTIU;
          3'b100:  dec_op = OP_XORI;
          3'b110:  dec_op = OP_ORI;
          3'b111:  dec_op = OP_ANDI;
          3'b001:  dec_op = OP_SLLI;
          default: dec_op = inst[30] ? OP_SRAI : OP_SRLI;
        endcase
      end
      7'b0110011: begin
        legal = 1'b1; use1 = 1'b1; use2 = 1'b1; has_rd = 1'b1;
        case (inst[14:12])
          3'b000:  dec_op = inst[30] ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = inst[30] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Operand resolution for both sources of the head entry.
  always_comb begin
    {src1_q, src1_v} = resolve(use1, reg_tag1, reg_data1, rob_ready1, rob_data1);
    {src2_q, src2_v} = resolve(use2, reg_tag2, reg_data2, rob_ready2, rob_data2);
  end

  // Queue storage write at the tail (payload needs no reset).
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_inst[tail] <= fetch_inst;
      q_pc[tail]   <= fetch_pc;
      q_ls[tail]   <= fetch_ls;
    end
  end

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered issue packet: pulses only in the cycle after a dispatch, data held otherwise.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rob_alloc   <= 1'b0;
      issue_rs    <= 1'b0;
      issue_lsb   <= 1'b0;
      illegal_out <= 1'b0;
      rob_op      <= '0;
      rob_rd      <= '0;
      rename_rd   <= '0;
      rename_tag  <= '0;
      iss_op      <= '0;
      iss_dest    <= '0;
      iss_qj      <= '0;
      iss_qk      <= '0;
      iss_vj      <= '0;
      iss_vk      <= '0;
      iss_imm     <= '0;
      iss_pc      <= '0;
    end else begin
      rob_alloc   <= dispatch;
      issue_rs    <= dispatch && !head_ls;
      issue_lsb   <= dispatch && head_ls;
      illegal_out <= illegal_out || drop;
      if (dispatch) begin
        rob_op     <= OP_W'(dec_op);
        rob_rd     <= has_rd ? inst[11:7] : 5'd0;
        rename_rd  <= has_rd ? inst[11:7] : 5'd0;
        rename_tag <= rob_tag;
        iss_op     <= OP_W'(dec_op);
        iss_dest   <= rob_tag;
        iss_qj     <= src1_q;
        iss_qk     <= src2_q;
        iss_vj     <= src1_v;
        iss_vk     <= src2_v;
        iss_imm    <= XLEN'($signed(imm32));
        iss_pc     <= q_pc[head];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed testbench for dispatch_queue: reset, decode/operand packets,
// fill/drain with wrap, flush, illegal drop, back-to-back dispatch.
module tb_dispatch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, clear_in;
  logic        fetch_valid, fetch_ls, fetch_ready;
  logic [31:0] fetch_inst, fetch_pc;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [3:0]  reg_tag1, reg_tag2, rob_tag, rename_tag, iss_dest, iss_qj, iss_qk, cdb_tag;
  logic [31:0] reg_data1, reg_data2, rob_data1, rob_data2, cdb_data;
  logic        rob_ready1, rob_ready2, rob_free, rob_alloc, rs_free, lsb_free;
  logic [5:0]  rob_op, iss_op;
  logic [4:0]  rob_rd, rename_rd;
  logic        issue_rs, issue_lsb, cdb_valid, illegal_out;
  logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  dispatch_queue #(.IQ_DEPTH(8), .XLEN(32), .TAG_W(4), .OP_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_ls(fetch_ls), .fetch_ready(fetch_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .reg_tag1(reg_tag1), .reg_tag2(reg_tag2), .reg_data1(reg_data1), .reg_data2(reg_data2),
    .rob_ready1(rob_ready1), .rob_ready2(rob_ready2), .rob_data1(rob_data1), .rob_data2(rob_data2),
    .rob_free(rob_free), .rob_tag(rob_tag), .rob_alloc(rob_alloc), .rob_op(rob_op),
    .rob_rd(rob_rd), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .rs_free(rs_free), .lsb_free(lsb_free), .issue_rs(issue_rs), .issue_lsb(issue_lsb),
    .iss_op(iss_op), .iss_dest(iss_dest), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .illegal_out(illegal_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_one(input logic [31:0] w, input logic ls);
    fetch_valid = 1'b1;
    fetch_inst  = w;
    fetch_pc    = pc_ctr;
    fetch_ls    = ls;
    tick();
    fetch_valid = 1'b0;
    fetch_ls    = 1'b0;
    pc_ctr      = pc_ctr + 32'd4;
  endtask

  function automatic logic [31:0] addi_x1(input int imm);
    return 32'h0000_0093 | (32'(imm) << 20);
  endfunction

  task automatic defaults();
    clear_in = 0; fetch_valid = 0; fetch_inst = '0; fetch_pc = '0; fetch_ls = 0;
    reg_tag1 = 0; reg_tag2 = 0; reg_data1 = '0; reg_data2 = '0;
    rob_ready1 = 0; rob_ready2 = 0; rob_data1 = '0; rob_data2 = '0;
    rob_free = 1; rob_tag = 4'd1; rs_free = 1; lsb_free = 1;
    cdb_valid = 0; cdb_tag = 0; cdb_data = '0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    defaults();
    repeat (2) tick();
    n_cmp++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL rst_fetch_ready got=%b exp=1", fetch_ready); end
    n_cmp++; if (rob_alloc !== 1'b0) begin n_err++; $display("FAIL rst_rob_alloc got=%b exp=0", rob_alloc); end
    n_cmp++; if ({issue_rs, issue_lsb} !== 2'b00) begin n_err++; $display("FAIL rst_issue got=%b exp=00", {issue_rs, issue_lsb}); end
    n_cmp++; if (illegal_out !== 1'b0) begin n_err++; $display("FAIL rst_illegal got=%b exp=0", illegal_out); end
    n_cmp++; if (iss_dest !== 4'd0 || iss_imm !== 32'd0) begin n_err++; $display("FAIL rst_data got dest=%h imm=%h exp=0", iss_dest, iss_imm); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    logic [31:0] pc0;
    defaults();
    rob_tag = 4'd3; reg_data2 = 32'h77;
    pc0 = pc_ctr;
    push_one(32'h0050_0093, 1'b0);
    n_cmp++; if (rs2_idx !== 5'd5 || rs1_idx !== 5'd0) begin n_err++; $display("FAIL addi_idx got rs1=%0d rs2=%0d exp 0/5", rs1_idx, rs2_idx); end
    n_cmp++; if (rob_alloc !== 1'b0) begin n_err++; $display("FAIL addi_early_pulse got=%b exp=0", rob_alloc); end
    tick();
    n_cmp++; if ({issue_rs, issue_lsb, rob_alloc} !== 3'b101) begin n_err++; $display("FAIL addi_pulses got=%b exp=101", {issue_rs, issue_lsb, rob_alloc}); end
    n_cmp++; if (iss_imm !== 32'd5) begin n_err++; $display("FAIL addi_imm got=%h exp=5", iss_imm); end
    n_cmp++; if (iss_qj !== 4'd0 || iss_vj !== 32'd0) begin n_err++; $display("FAIL addi_j got q=%h v=%h exp 0/0", iss_qj, iss_vj); end
    n_cmp++; if (iss_qk !== 4'd0 || iss_vk !== 32'd0) begin n_err++; $display("FAIL addi_k_unused got q=%h v=%h exp 0/0", iss_qk, iss_vk); end
    n_cmp++; if (iss_dest !== 4'd3 || rename_tag !== 4'd3) begin n_err++; $display("FAIL addi_tag got dest=%h ren=%h exp 3", iss_dest, rename_tag); end
    n_cmp++; if (rename_rd !== 5'd1 || rob_rd !== 5'd1) begin n_err++; $display("FAIL addi_rd got ren=%0d rob=%0d exp 1", rename_rd, rob_rd); end
    n_cmp++; if (iss_op !== 6'd19 || rob_op !== 6'd19) begin n_err++; $display("FAIL addi_op got=%0d/%0d exp=19", iss_op, rob_op); end
    n_cmp++; if (iss_pc !== pc0) begin n_err++; $display("FAIL addi_pc got=%h exp=%h", iss_pc, pc0); end
    tick();
    n_cmp++; if ({issue_rs, rob_alloc} !== 2'b00) begin n_err++; $display("FAIL addi_pulse_width got=%b exp=00", {issue_rs, rob_alloc}); end
    n_cmp++; if (iss_imm !== 32'd5) begin n_err++; $display("FAIL addi_hold got=%h exp=5", iss_imm); end
  endtask

  task automatic test_operands();
    logic [3:0]  exp_qj;
    logic [31:0] exp_vj;
    defaults();
    // LW x2,8(x1) waiting on tag 3; CDB broadcasts tag 3 in the dispatch cycle
    rob_tag = 4'd4; reg_tag1 = 4'd3; rob_ready1 = 1'b0; reg_data1 = 32'hDEAD;
    push_one(32'h0080_A103, 1'b1);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h10;
    tick();
    cdb_valid = 1'b0;
`ifdef DISPATCH_CDB_FWD_EN
    exp_qj = 4'd0; exp_vj = 32'h10;
`else
    exp_qj = 4'd3; exp_vj = 32'h0;
`endif
    n_cmp++; if ({issue_lsb, issue_rs, rob_alloc} !== 3'b101) begin n_err++; $display("FAIL lw_pulses got=%b exp=101", {issue_lsb, issue_rs, rob_alloc}); end
    n_cmp++; if (iss_qj !== exp_qj || iss_vj !== exp_vj) begin n_err++; $display("FAIL lw_j got q=%h v=%h exp q=%h v=%h", iss_qj, iss_vj, exp_qj, exp_vj); end
    n_cmp++; if (iss_imm !== 32'd8 || iss_op !== 6'd13) begin n_err++; $display("FAIL lw_imm_op got imm=%h op=%0d exp 8/13", iss_imm, iss_op); end
    n_cmp++; if (rename_rd !== 5'd2 || iss_dest !== 4'd4) begin n_err++; $display("FAIL lw_rd_dest got rd=%0d dest=%h exp 2/4", rename_rd, iss_dest); end
    // ADD x3,x1,x2: src1 ready in ROB, src2 from regfile
    reg_tag1 = 4'd5; rob_ready1 = 1'b1; rob_data1 = 32'hAAAA; reg_data1 = 32'hBEEF;
    reg_tag2 = 4'd0; reg_data2 = 32'h1234; rob_data2 = 32'h5555;
    push_one(32'h0020_81B3, 1'b0);
    tick();
    n_cmp++; if (issue_rs !== 1'b1 || iss_op !== 6'd28) begin n_err++; $display("FAIL add_issue got rs=%b op=%0d exp 1/28", issue_rs, iss_op); end
    n_cmp++; if (iss_qj !== 4'd0 || iss_vj !== 32'hAAAA) begin n_err++; $display("FAIL add_j_rob got q=%h v=%h exp 0/aaaa", iss_qj, iss_vj); end
    n_cmp++; if (iss_qk !== 4'd0 || iss_vk !== 32'h1234) begin n_err++; $display("FAIL add_k_reg got q=%h v=%h exp 0/1234", iss_qk, iss_vk); end
    n_cmp++; if (iss_imm !== 32'd0) begin n_err++; $display("FAIL add_imm got=%h exp=0", iss_imm); end
  endtask

  task automatic test_formats();
    logic [31:0] w   [4];
    logic        ls  [4];
    logic [5:0]  op  [4];
    logic [31:0] imm [4];
    logic [4:0]  rd  [4];
    logic [31:0] vj  [4];
    logic [31:0] vk  [4];
    defaults();
    reg_data1 = 32'h111; reg_data2 = 32'h222;
    // LUI x5,0x12345 / BNE x1,x2,-4 / SW x2,12(x1) / ADDI x1,x2,-1
    w[0] = 32'h1234_52B7; ls[0] = 0; op[0] = 6'd1;  imm[0] = 32'h1234_5000; rd[0] = 5; vj[0] = 0;      vk[0] = 0;
    w[1] = 32'hFE20_9EE3; ls[1] = 0; op[1] = 6'd6;  imm[1] = 32'hFFFF_FFFC; rd[1] = 0; vj[1] = 32'h111; vk[1] = 32'h222;
    w[2] = 32'h0020_A623; ls[2] = 1; op[2] = 6'd18; imm[2] = 32'h0000_000C; rd[2] = 0; vj[2] = 32'h111; vk[2] = 32'h222;
    w[3] = 32'hFFF1_0093; ls[3] = 0; op[3] = 6'd19; imm[3] = 32'hFFFF_FFFF; rd[3] = 1; vj[3] = 32'h111; vk[3] = 0;
    for (int i = 0; i < 4; i++) begin
      push_one(w[i], ls[i]);
      tick();
      n_cmp++; if ({issue_rs, issue_lsb} !== {~ls[i], ls[i]}) begin n_err++; $display("FAIL fmt%0d_unit got=%b exp=%b", i, {issue_rs, issue_lsb}, {~ls[i], ls[i]}); end
      n_cmp++; if (iss_op !== op[i]) begin n_err++; $display("FAIL fmt%0d_op got=%0d exp=%0d", i, iss_op, op[i]); end
      n_cmp++; if (iss_imm !== imm[i]) begin n_err++; $display("FAIL fmt%0d_imm got=%h exp=%h", i, iss_imm, imm[i]); end
      n_cmp++; if (rob_rd !== rd[i] || rename_rd !== rd[i]) begin n_err++; $display("FAIL fmt%0d_rd got=%0d/%0d exp=%0d", i, rob_rd, rename_rd, rd[i]); end
      n_cmp++; if (iss_vj !== vj[i] || iss_vk !== vk[i]) begin n_err++; $display("FAIL fmt%0d_vals got=%h/%h exp=%h/%h", i, iss_vj, iss_vk, vj[i], vk[i]); end
    end
  endtask

  task automatic test_full();
    defaults();
    rs_free = 1'b0;
    for (int k = 1; k <= 8; k++) push_one(addi_x1(k), 1'b0);
    n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", fetch_ready); end
    push_one(addi_x1(9), 1'b0);
    n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL full_ninth got=%b exp=0", fetch_ready); end
    n_cmp++; if (issue_rs !== 1'b0) begin n_err++; $display("FAIL full_blocked got=%b exp=0", issue_rs); end
    rs_free = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (issue_rs !== 1'b1 || iss_imm !== 32'(k)) begin n_err++; $display("FAIL drain%0d got rs=%b imm=%h exp 1/%h", k, issue_rs, iss_imm, 32'(k)); end
    end
    tick();
    n_cmp++; if (issue_rs !== 1'b0 || fetch_ready !== 1'b1) begin n_err++; $display("FAIL drain_end got rs=%b rdy=%b exp 0/1", issue_rs, fetch_ready); end
  endtask

  task automatic test_clear();
    defaults();
    rs_free = 1'b0;
    for (int k = 33; k <= 36; k++) push_one(addi_x1(k), 1'b0);
    fetch_valid = 1'b1; fetch_inst = addi_x1(37); clear_in = 1'b1;
    tick();
    fetch_valid = 1'b0; clear_in = 1'b0; rs_free = 1'b1;
    n_cmp++; if (fetch_ready !== 1'b1 || rob_alloc !== 1'b0) begin n_err++; $display("FAIL clr_state got rdy=%b alloc=%b exp 1/0", fetch_ready, rob_alloc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({issue_rs, issue_lsb, rob_alloc} !== 3'b000) begin n_err++; $display("FAIL clr_empty%0d got=%b exp=000", i, {issue_rs, issue_lsb, rob_alloc}); end
    end
    push_one(addi_x1(38), 1'b0);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    n_cmp++; if ({issue_rs, rob_alloc} !== 2'b00) begin n_err++; $display("FAIL clr_blocks_dispatch got=%b exp=00", {issue_rs, rob_alloc}); end
    tick();
    n_cmp++; if (issue_rs !== 1'b0) begin n_err++; $display("FAIL clr_flushed got=%b exp=0", issue_rs); end
  endtask

  task automatic test_illegal();
    defaults();
    n_cmp++; if (illegal_out !== 1'b0) begin n_err++; $display("FAIL ill_pre got=%b exp=0", illegal_out); end
    push_one(32'hFFFF_FFFF, 1'b0);
    push_one(32'h0020_81B3, 1'b0);
    n_cmp++; if ({rob_alloc, issue_rs, issue_lsb} !== 3'b000) begin n_err++; $display("FAIL ill_no_issue got=%b exp=000", {rob_alloc, issue_rs, issue_lsb}); end
    n_cmp++; if (illegal_out !== 1'b1) begin n_err++; $display("FAIL ill_flag got=%b exp=1", illegal_out); end
    tick();
    n_cmp++; if (issue_rs !== 1'b1 || iss_op !== 6'd28) begin n_err++; $display("FAIL ill_next_add got rs=%b op=%0d exp 1/28", issue_rs, iss_op); end
    tick();
    n_cmp++; if (illegal_out !== 1'b1) begin n_err++; $display("FAIL ill_sticky got=%b exp=1", illegal_out); end
  endtask

  task automatic test_back_to_back();
    defaults();
    rob_free = 1'b0;
    push_one(addi_x1(48), 1'b0);
    tick();
    n_cmp++; if (rob_alloc !== 1'b0) begin n_err++; $display("FAIL b2b_rob_full got=%b exp=0", rob_alloc); end
    rob_free = 1'b1;
    tick();
    n_cmp++; if (rob_alloc !== 1'b1 || iss_imm !== 32'd48) begin n_err++; $display("FAIL b2b_rob_free got a=%b imm=%h exp 1/30", rob_alloc, iss_imm); end
    fetch_valid = 1'b1;
    for (int k = 49; k <= 52; k++) begin
      fetch_inst = addi_x1(k);
      tick();
      if (k > 49) begin
        n_cmp++; if (issue_rs !== 1'b1 || iss_imm !== 32'(k - 1)) begin n_err++; $display("FAIL b2b%0d got rs=%b imm=%h exp 1/%h", k, issue_rs, iss_imm, 32'(k - 1)); end
      end
    end
    fetch_valid = 1'b0;
    tick();
    n_cmp++; if (issue_rs !== 1'b1 || iss_imm !== 32'd52) begin n_err++; $display("FAIL b2b_last got rs=%b imm=%h exp 1/34", issue_rs, iss_imm); end
    tick();
    n_cmp++; if (issue_rs !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", issue_rs); end
  endtask

  task automatic test_reset_midstream();
    defaults();
    rs_free = 1'b0;
    for (int k = 64; k <= 66; k++) push_one(addi_x1(k), 1'b0);
    #2 rst_in = 1'b0;
    #1;
    n_cmp++; if (fetch_ready !== 1'b1 || illegal_out !== 1'b0) begin n_err++; $display("FAIL mrst_async got rdy=%b ill=%b exp 1/0", fetch_ready, illegal_out); end
    tick();
    rst_in = 1'b1; rs_free = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({issue_rs, rob_alloc} !== 2'b00) begin n_err++; $display("FAIL mrst_empty%0d got=%b exp=00", i, {issue_rs, rob_alloc}); end
    end
    push_one(addi_x1(7), 1'b0);
    n_cmp++; if (issue_rs !== 1'b0) begin n_err++; $display("FAIL mrst_early got=%b exp=0", issue_rs); end
    tick();
    n_cmp++; if (issue_rs !== 1'b1 || iss_imm !== 32'd7) begin n_err++; $display("FAIL mrst_first got rs=%b imm=%h exp 1/7", issue_rs, iss_imm); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_operands();
    test_formats();
    test_full();
    test_clear();
    test_illegal();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
